// File: rtl/mem_arbiter_fifo_if.sv
// Requester-side and memory-side signal bundle for mem_arbiter_fifo.
// The master modport is the requester/test side; the slave modport is the arbiter.
interface mem_arbiter_fifo_if #(
    parameter int N      = 3,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]        req;
    logic [N*ADDR_W-1:0] addr_in;
    logic [N*DATA_W-1:0] wdata_in;
    logic [N-1:0]        we_in;

    logic [N-1:0]        grant;
    logic                mem_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_we;
    logic                timeout_pulse;
    logic [CNT_W-1:0]    queue_count;

    modport master (
        output req, addr_in, wdata_in, we_in,
        input  grant, mem_en, mem_addr, mem_wdata, mem_we, timeout_pulse, queue_count
    );

    modport slave (
        input  req, addr_in, wdata_in, we_in,
        output grant, mem_en, mem_addr, mem_wdata, mem_we, timeout_pulse, queue_count
    );
endinterface

// File: rtl/mem_arbiter_fifo.sv
// First-come-first-served arbiter: N requesters share one memory port.
// Requests queue in arrival order in a circular buffer of channel indices;
// stale entries are skipped at pop time and an optional hold limit forces release.
module mem_arbiter_fifo #(
    parameter int N        = 3,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 0
) (
    input logic               clk,
    input logic               reset,
    mem_arbiter_fifo_if.slave bus
);
    localparam int IDX_W  = $clog2(N);
    localparam int CNT_W  = $clog2(N + 1);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {IDLE, BUSY} stateT;

    stateT             state, stateNext;
    logic [N-1:0]      grantQ, grantNext;
    logic [HOLD_W-1:0] holdQ, holdNext;
    logic              timeoutQ, timeoutNext;

    logic [IDX_W-1:0]  fifo [N];
    logic [IDX_W-1:0]  headQ, headNext;
    logic [IDX_W-1:0]  tailQ, tailNext;
    logic [CNT_W-1:0]  countQ, countNext;
    logic [N-1:0]      queuedQ, queuedNext;

    logic [N-1:0]      newReq;
    logic              pushEn;
    logic              popEn;
    logic [IDX_W-1:0]  pushIdx;
    logic [IDX_W-1:0]  headIdx;

    logic [ADDR_W-1:0] addrMux;
    logic [DATA_W-1:0] wdataMux;
    logic              weMux;

    function automatic logic [IDX_W-1:0] nextPtr(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(N - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    // Pick the lowest-index requester that is neither queued nor granted.
    always_comb begin
        newReq  = bus.req & ~(queuedQ | grantQ);
        pushEn  = 1'b0;
        pushIdx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (newReq[i] && !pushEn) begin
                pushEn  = 1'b1;
                pushIdx = IDX_W'(i);
            end
        end
    end

    // Next-state logic: pop/grant in IDLE, release or forced release in BUSY.
    always_comb begin
        headIdx     = fifo[headQ];
        popEn       = 1'b0;
        stateNext   = state;
        grantNext   = grantQ;
        holdNext    = holdQ;
        timeoutNext = 1'b0;
        case (state)
            IDLE: begin
                if (countQ != '0) begin
                    popEn = 1'b1;
                    if (bus.req[headIdx]) begin
                        grantNext          = '0;
                        grantNext[headIdx] = 1'b1;
                        holdNext           = '0;
                        stateNext          = BUSY;
                    end
                end
            end
            BUSY: begin
                if ((bus.req & grantQ) == '0) begin
                    grantNext = '0;
                    stateNext = IDLE;
                end else if (MAX_HOLD > 0 && holdQ == HOLD_LAST) begin
                    grantNext   = '0;
                    timeoutNext = 1'b1;
                    stateNext   = IDLE;
                end else begin
                    holdNext = holdQ + HOLD_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Queue bookkeeping; a pushed channel is never the popped head, so both apply.
    always_comb begin
        queuedNext = queuedQ;
        headNext   = headQ;
        tailNext   = tailQ;
        if (popEn) begin
            queuedNext[headIdx] = 1'b0;
            headNext            = nextPtr(headQ);
        end
        if (pushEn) begin
            queuedNext[pushIdx] = 1'b1;
            tailNext            = nextPtr(tailQ);
        end
        countNext = countQ + CNT_W'(pushEn) - CNT_W'(popEn);
    end

    // State, grant and queue registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grantQ   <= '0;
            holdQ    <= '0;
            timeoutQ <= 1'b0;
            headQ    <= '0;
            tailQ    <= '0;
            countQ   <= '0;
            queuedQ  <= '0;
            for (int unsigned i = 0; i < N; i++) fifo[i] <= '0;
        end else begin
            state    <= stateNext;
            grantQ   <= grantNext;
            holdQ    <= holdNext;
            timeoutQ <= timeoutNext;
            headQ    <= headNext;
            tailQ    <= tailNext;
            countQ   <= countNext;
            queuedQ  <= queuedNext;
            if (pushEn) fifo[tailQ] <= pushIdx;
        end
    end

    // Memory-side mux; grant is one-hot so OR-ing masked channels needs no priority.
    always_comb begin
        addrMux  = '0;
        wdataMux = '0;
        weMux    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grantQ[i]) begin
                addrMux  |= bus.addr_in[i*ADDR_W +: ADDR_W];
                wdataMux |= bus.wdata_in[i*DATA_W +: DATA_W];
                weMux    |= bus.we_in[i];
            end
        end
    end

    assign bus.grant         = grantQ;
    assign bus.mem_en        = |grantQ;
    assign bus.mem_addr      = addrMux;
    assign bus.mem_wdata     = wdataMux;
    assign bus.mem_we        = weMux;
    assign bus.timeout_pulse = timeoutQ;
    assign bus.queue_count   = countQ;
endmodule

// File: tb/tb_mem_arbiter_fifo.sv
// Testbench for mem_arbiter_fifo: directed scenarios plus random traffic,
// compared each cycle against a queue-based behavioural model.
module tb_mem_arbiter_fifo;
    localparam int N        = 3;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_arbiter_fifo_if #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter_fifo #(
        .N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: FIFO of channel numbers, granted channel, cycles granted so far.
    int mq[$];
    int mg;
    int mHold;
    bit expTo;

    int holdLen[N];
    bit randMode;
    int nVec;
    int nMis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mg    = -1;
        mHold = 0;
        expTo = 1'b0;
    endtask

    task automatic modelEdge();
        bit [N-1:0] pend;
        int newCh;
        int popped;
        if (reset) begin
            modelReset();
            return;
        end
        pend = '0;
        foreach (mq[k]) pend[mq[k]] = 1'b1;
        if (mg >= 0) pend[mg] = 1'b1;
        newCh = -1;
        for (int i = 0; i < N; i++)
            if (bus.req[i] && !pend[i] && newCh < 0) newCh = i;
        expTo = 1'b0;
        if (mg < 0) begin
            if (mq.size() > 0) begin
                popped = mq.pop_front();
                if (bus.req[popped]) begin
                    mg    = popped;
                    mHold = 1;
                end
            end
        end else if (!bus.req[mg]) begin
            mg = -1;
        end else if (mHold == MAX_HOLD) begin
            mg    = -1;
            expTo = 1'b1;
        end else begin
            mHold++;
        end
        if (newCh >= 0) mq.push_back(newCh);
    endtask

    task automatic checkAll();
        logic [N-1:0]      eg;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              ew;
        eg = '0; ea = '0; ed = '0; ew = 1'b0;
        if (mg >= 0) begin
            eg[mg] = 1'b1;
            ea = bus.addr_in[mg*ADDR_W +: ADDR_W];
            ed = bus.wdata_in[mg*DATA_W +: DATA_W];
            ew = bus.we_in[mg];
        end
        chk("grant",         64'(bus.grant),         64'(eg));
        chk("mem_en",        64'(bus.mem_en),        64'(mg >= 0));
        chk("mem_addr",      64'(bus.mem_addr),      64'(ea));
        chk("mem_wdata",     64'(bus.mem_wdata),     64'(ed));
        chk("mem_we",        64'(bus.mem_we),        64'(ew));
        chk("timeout_pulse", 64'(bus.timeout_pulse), 64'(expTo));
        chk("queue_count",   64'(bus.queue_count),   64'(mq.size()));
    endtask

    task automatic randData();
        for (int i = 0; i < N; i++) begin
            bus.addr_in[i*ADDR_W +: ADDR_W]  = ADDR_W'($urandom);
            bus.wdata_in[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            bus.we_in[i]                     = 1'($urandom);
        end
    endtask

    // Requester behaviour: a granted channel drops req after holdLen cycles.
    task automatic policy();
        for (int i = 0; i < N; i++) begin
            if (i == mg) begin
                if (mHold >= holdLen[i]) bus.req[i] = 1'b0;
            end else if (randMode) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.req[i] = 1'b1;
                        holdLen[i] = int'($urandom_range(1, 6));
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
        end
        if (randMode) randData();
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkAll();
        policy();
    endtask

    initial begin
        int cnt;
        int gaps;
        int order[$];
        logic [N-1:0] prevG;
        bit seen0;
        bit seen2;
        bit seenTo;

        nVec = 0;
        nMis = 0;
        randMode = 1'b0;
        bus.req = '0;
        bus.addr_in = '0;
        bus.wdata_in = '0;
        bus.we_in = '0;
        for (int i = 0; i < N; i++) holdLen[i] = 2;
        modelReset();

        // Reset state
        reset = 1'b1;
        #1;
        checkAll();
        step();
        step();

        // Reset mid-grant, then regrant two edges after release
        reset = 1'b0;
        bus.req = 3'b001;
        holdLen[0] = 100;
        randData();
        step();
        chk("first_push_count", 64'(bus.queue_count), 64'd1);
        step();
        chk("first_grant", 64'(bus.grant), 64'd1);
        step();
        step();
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        chk("rst_mid_grant", 64'(bus.grant), 64'd0);
        chk("rst_mid_qcount", 64'(bus.queue_count), 64'd0);
        step();
        #1 reset = 1'b0;
        step();
        step();
        chk("rst_regrant", 64'(bus.grant), 64'd1);
        bus.req = '0;
        step();
        step();

        // Burst 000 -> 111: grants in index order with idle gaps between
        for (int i = 0; i < N; i++) holdLen[i] = 2;
        bus.req = 3'b111;
        prevG = '0;
        gaps = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.grant != '0 && prevG != '0 && bus.grant != prevG) gaps++;
            if (bus.grant != '0 && prevG == '0)
                for (int i = 0; i < N; i++) if (bus.grant[i]) order.push_back(i);
            prevG = bus.grant;
        end
        chk("burst_gap", 64'(gaps), 64'd0);
        chk("burst_ngrants", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            chk("burst_order0", 64'(order[0]), 64'd0);
            chk("burst_order1", 64'(order[1]), 64'd1);
            chk("burst_order2", 64'(order[2]), 64'd2);
        end

        // Arrival order: 2 first, 0 three cycles later
        bus.addr_in = {8'h5A, 8'h77, 8'h11};
        holdLen[2] = 3;
        holdLen[0] = 2;
        bus.req = 3'b100;
        step();
        step();
        step();
        bus.req[0] = 1'b1;
        seen0 = 1'b0;
        seen2 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.grant == 3'b100) begin
                seen2 = 1'b1;
                chk("arrival_addr2", 64'(bus.mem_addr), 64'h5A);
            end
            if (bus.grant == 3'b001) begin
                chk("arrival_after2", 64'(seen2), 64'd1);
                chk("arrival_addr0", 64'(bus.mem_addr), 64'h11);
                seen0 = 1'b1;
            end
        end
        chk("arrival_seen0", 64'(seen0), 64'd1);

        // Stale entry: channel 1 withdraws while queued behind busy channel 0
        holdLen[0] = 3;
        bus.req = 3'b001;
        for (int k = 0; k < 5 && bus.grant != 3'b001; k++) step();
        chk("stale_busy0", 64'(bus.grant), 64'd1);
        bus.req[1] = 1'b1;
        step();
        chk("stale_queued", 64'(bus.queue_count), 64'd1);
        bus.req[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.grant == 3'b010) cnt++;
        end
        chk("stale_no_grant", 64'(cnt), 64'd0);
        chk("stale_drained", 64'(bus.queue_count), 64'd0);

        // Forced release after MAX_HOLD cycles; holder re-queues behind channel 1
        holdLen[0] = 100;
        holdLen[1] = 2;
        bus.req = 3'b001;
        for (int k = 0; k < 5 && bus.grant != 3'b001; k++) step();
        cnt = (bus.grant == 3'b001) ? 1 : 0;
        bus.req[1] = 1'b1;
        seenTo = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.timeout_pulse) begin
                seenTo = 1'b1;
                break;
            end
            if (bus.grant == 3'b001) cnt++;
        end
        chk("timeout_seen", 64'(seenTo), 64'd1);
        chk("timeout_hold_len", 64'(cnt), 64'(MAX_HOLD));
        step();
        chk("timeout_next_grant", 64'(bus.grant), 64'd2);
        chk("timeout_requeued", 64'(bus.queue_count), 64'd1);
        holdLen[0] = 1;
        for (int k = 0; k < 12; k++) step();

        // Random traffic: wraps the pointers many times, mixes push/pop/stale/timeout
        randMode = 1'b1;
        for (int k = 0; k < 400; k++) step();
        randMode = 1'b0;
        bus.req = '0;
        for (int k = 0; k < 6; k++) step();
        chk("final_idle_count", 64'(bus.queue_count), 64'd0);
        chk("final_idle_grant", 64'(bus.grant), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
